// File: rtl/tcp_rx_ctrl_mc.sv
// Multi-connection TCP receive controller: matches parsed headers to connection slots,
// classifies them into receive messages and queues them for the TCP state machines.

package tcp_pkg;

    typedef enum logic [2:0] {
        RX_MSG_RECV_SYNACK = 3'd0,
        RX_MSG_RECV_ACK    = 3'd1,
        RX_MSG_RECV_FIN    = 3'd2,
        RX_MSG_RECV_RST    = 3'd3,
        RX_MSG_RECV_DUPACK = 3'd4
    } rx_msg_t;

endpackage

module tcp_rx_ctrl_mc #(
    parameter int unsigned NUM_CONN       = 4,
    parameter int unsigned MSG_FIFO_DEPTH = 4,
    parameter int unsigned DUPACK_THRESH  = 3,
    localparam int unsigned CW = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CONN-1:0]      i_conn_en,
    input  logic [NUM_CONN*16-1:0]   i_conn_local_port,
    input  logic [NUM_CONN*16-1:0]   i_conn_remote_port,
    input  logic [31:0]              i_seq_number,
    input  logic [31:0]              i_ack_number,
    input  logic [15:0]              i_source_port,
    input  logic [15:0]              i_dest_port,
    input  logic [7:0]               i_flags,
    input  logic [15:0]              i_window_size,
    input  logic                     i_hdr_valid,
    output tcp_pkg::rx_msg_t         o_rx_msg,
    output logic [CW-1:0]            o_rx_conn,
    output logic [31:0]              o_rx_seq,
    output logic [31:0]              o_rx_ack,
    output logic [15:0]              o_rx_window,
    output logic                     o_rx_msg_valid,
    input  logic                     i_rx_msg_ack,
    output logic                     o_unmatched,
    output logic                     o_overflow,
    output logic [7:0]               o_drop_count
);

    import tcp_pkg::*;

    localparam int unsigned PW = $clog2(MSG_FIFO_DEPTH);
    localparam int unsigned DW = $clog2(DUPACK_THRESH + 1);

    localparam int unsigned FLAG_FIN = 0;
    localparam int unsigned FLAG_SYN = 1;
    localparam int unsigned FLAG_RST = 2;
    localparam int unsigned FLAG_ACK = 4;

    typedef struct packed {
        rx_msg_t       msg;
        logic [CW-1:0] conn;
        logic [31:0]   seq;
        logic [31:0]   ack;
        logic [15:0]   win;
    } entry_t;

    // Per-slot receive state
    logic [31:0]         last_ack_q [NUM_CONN];
    logic [NUM_CONN-1:0] la_valid_q;
    logic [DW-1:0]       dupcnt_q   [NUM_CONN];

    // Classification stage
    logic   p_valid_q;
    entry_t p_entry_q;
    logic   unmatched_q;

    // Message FIFO
    entry_t        fifo_q [MSG_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          overflow_q;
    logic [7:0]    drop_count_q;

    logic          hit;
    logic [CW-1:0] hit_idx;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        // Walk downward so the lowest matching slot is the one left standing.
        for (int k = int'(NUM_CONN) - 1; k >= 0; k--) begin
            if (i_conn_en[k] &&
                i_dest_port == i_conn_local_port[16*k +: 16] &&
                i_source_port == i_conn_remote_port[16*k +: 16]) begin
                hit     = 1'b1;
                hit_idx = CW'(k);
            end
        end
    end

    logic [31:0] cur_last;
    logic        cur_lav;
    logic [DW-1:0] cur_dc;
    logic [DW-1:0] dc_inc;

    assign cur_last = last_ack_q[hit_idx];
    assign cur_lav  = la_valid_q[hit_idx];
    assign cur_dc   = dupcnt_q[hit_idx];
    assign dc_inc   = cur_dc + 1'b1;

    logic          gen;
    rx_msg_t       gen_msg;
    logic          st_upd;
    logic [31:0]   nxt_last;
    logic          nxt_lav;
    logic [DW-1:0] nxt_dc;

    always_comb begin
        gen      = 1'b0;
        gen_msg  = RX_MSG_RECV_SYNACK;
        st_upd   = 1'b0;
        nxt_last = cur_last;
        nxt_lav  = cur_lav;
        nxt_dc   = cur_dc;
        if (i_hdr_valid && hit) begin
            if (i_flags[FLAG_RST]) begin
                gen     = 1'b1;
                gen_msg = RX_MSG_RECV_RST;
                st_upd  = 1'b1;
                nxt_lav = 1'b0;
                nxt_dc  = '0;
            end else if (i_flags[FLAG_SYN] && i_flags[FLAG_ACK]) begin
                gen      = 1'b1;
                gen_msg  = RX_MSG_RECV_SYNACK;
                st_upd   = 1'b1;
                nxt_last = i_ack_number;
                nxt_lav  = 1'b1;
                nxt_dc   = '0;
            end else if (i_flags[FLAG_FIN]) begin
                gen     = 1'b1;
                gen_msg = RX_MSG_RECV_FIN;
            end else if (i_flags[FLAG_ACK]) begin
                st_upd = 1'b1;
                if (!cur_lav || i_ack_number != cur_last) begin
                    gen      = 1'b1;
                    gen_msg  = RX_MSG_RECV_ACK;
                    nxt_last = i_ack_number;
                    nxt_lav  = 1'b1;
                    nxt_dc   = '0;
                end else if (dc_inc == DW'(DUPACK_THRESH)) begin
                    gen     = 1'b1;
                    gen_msg = RX_MSG_RECV_DUPACK;
                    nxt_dc  = '0;
                end else begin
                    nxt_dc = dc_inc;
                end
            end
        end
    end

    // Slot state commits on the same edge as classification, so a header on the
    // next cycle already sees it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < int'(NUM_CONN); k++) begin
                last_ack_q[k] <= '0;
                dupcnt_q[k]   <= '0;
            end
            la_valid_q <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_CONN); k++) begin
                if (!i_conn_en[k]) begin
                    la_valid_q[k] <= 1'b0;
                    dupcnt_q[k]   <= '0;
                end else if (st_upd && hit_idx == CW'(k)) begin
                    last_ack_q[k] <= nxt_last;
                    la_valid_q[k] <= nxt_lav;
                    dupcnt_q[k]   <= nxt_dc;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            p_valid_q   <= 1'b0;
            p_entry_q   <= '0;
            unmatched_q <= 1'b0;
        end else begin
            p_valid_q   <= gen;
            p_entry_q   <= '{msg: gen_msg, conn: hit_idx, seq: i_seq_number,
                             ack: i_ack_number, win: i_window_size};
            unmatched_q <= i_hdr_valid && !hit;
        end
    end

    logic pop;
    logic full;
    logic push;
    logic drop;

    assign pop  = i_rx_msg_ack && (count_q != '0);
    assign full = (count_q == (PW+1)'(MSG_FIFO_DEPTH));
    assign push = p_valid_q && (!full || pop);
    assign drop = p_valid_q && full && !pop;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < int'(MSG_FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= p_entry_q;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 8'hFF) begin
                    drop_count_q <= drop_count_q + 8'd1;
                end
            end
        end
    end

    entry_t head;
    assign head = fifo_q[rd_ptr_q];

    assign o_rx_msg       = head.msg;
    assign o_rx_conn      = head.conn;
    assign o_rx_seq       = head.seq;
    assign o_rx_ack       = head.ack;
    assign o_rx_window    = head.win;
    assign o_rx_msg_valid = (count_q != '0);
    assign o_unmatched    = unmatched_q;
    assign o_overflow     = overflow_q;
    assign o_drop_count   = drop_count_q;

endmodule

// File: doc/tcp_rx_ctrl_mc.md
Name: tcp_rx_ctrl_mc

Overview:
Multi-connection successor to the TCP receive controller. It classifies each parsed TCP header into a receive message and matches it against NUM_CONN connection slots by port pair. Duplicate ACKs are tracked per connection. Messages, tagged with connection index and header fields, are queued in a small FIFO and handed to the TCP state machine through a valid/ack handshake. The block sits between the TCP header parser and the per-connection TCP state machines in the network processor.

Parameters:
NUM_CONN, 4, number of connection slots (>=1)
MSG_FIFO_DEPTH, 4, message FIFO entries (power of 2, >=2)
DUPACK_THRESH, 3, duplicate ACKs needed to emit RX_MSG_RECV_DUPACK (>=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-low reset
i_conn_en  in  NUM_CONN  slot enable, one bit per slot
i_conn_local_port  in  NUM_CONN*16  local port per slot; slot k is at [16k+:16]
i_conn_remote_port  in  NUM_CONN*16  remote port per slot; same packing
i_seq_number  in  32  header sequence number
i_ack_number  in  32  header acknowledgement number
i_source_port  in  16  header source port
i_dest_port  in  16  header destination port
i_flags  in  8  header flags: FIN=bit0, SYN=bit1, RST=bit2, PSH=bit3, ACK=bit4
i_window_size  in  16  header window
i_hdr_valid  in  1  single-cycle strobe; header fields valid this cycle
o_rx_msg  out  tcp_pkg::rx_msg_t  message type
o_rx_conn  out  max(1,$clog2(NUM_CONN))  slot index of the message
o_rx_seq  out  32  seq of the message
o_rx_ack  out  32  ack of the message
o_rx_window  out  16  window of the message
o_rx_msg_valid  out  1  FIFO head is valid
i_rx_msg_ack  in  1  consumer pops the head
o_unmatched  out  1  one-cycle pulse: header matched no enabled slot
o_overflow  out  1  sticky: a message was dropped because the FIFO was full
o_drop_count  out  8  saturating count of dropped messages

Behaviour:
- Reset (i_rst low, async): FIFO empty; o_rx_msg_valid=0; o_rx_msg=RX_MSG_RECV_SYNACK (encoding 0); o_rx_conn, o_rx_seq, o_rx_ack, o_rx_window=0; o_unmatched=0; o_overflow=0; o_drop_count=0; all last_ack valid bits and dupcnt values=0. Reset mid-operation discards queued messages.
- tcp_pkg::rx_msg_t gains RX_MSG_RECV_ACK, RX_MSG_RECV_FIN, RX_MSG_RECV_RST and RX_MSG_RECV_DUPACK.
- Match: slot k hits when i_conn_en[k], dest_port==local_port[k] and source_port==remote_port[k]. The lowest hit index wins. No hit: o_unmatched pulses the next cycle, no message is generated, no state changes.
- Classification, priority high to low:
  - RST set -> RECV_RST.
  - SYN and ACK both set -> RECV_SYNACK. Exact two-bit test, not any-bit.
  - FIN set -> RECV_FIN.
  - ACK set -> ACK path.
  - Anything else (e.g. SYN alone, PSH alone) is ignored silently.
- ACK path, per slot state last_ack[32], la_valid, dupcnt:
  - If !la_valid or ack_number!=last_ack: emit RECV_ACK, last_ack<=ack_number, la_valid<=1, dupcnt<=0.
  - Otherwise dupcnt++. When the incremented value reaches DUPACK_THRESH: emit RECV_DUPACK and set dupcnt<=0. Below threshold: no message.
- Per-slot state updates for other message types:
  - SYNACK: last_ack<=ack_number, la_valid<=1, dupcnt<=0.
  - RST: la_valid<=0, dupcnt<=0.
  - FIN: state unchanged.
- i_conn_en[k] low clears la_valid[k] and dupcnt[k] every cycle.
- Pipeline: header strobe in cycle N. Classification and slot state update are registered at N+1, and the FIFO write occurs at N+1. With an empty FIFO, o_rx_msg_valid rises at N+2. Back-to-back strobes are accepted every cycle. Two same-slot ACKs on consecutive cycles see each other's updates, so slot state is forwarded.
- FIFO/handshake:
  - Head outputs stay stable while valid and not acked.
  - A pop occurs on i_rx_msg_ack && o_rx_msg_valid; ack while empty is ignored.
  - Write when full with no simultaneous pop: drop the message, set o_overflow, o_drop_count++ saturating at 255. Slot state still updates.
  - Write when full with a simultaneous pop: accepted.
  - Pointers wrap modulo MSG_FIFO_DEPTH.

Test Plan:
- Slot0 local=0x1234/remote=0x0050 enabled; header flags=0x12, seq=0x100, ack=0x200 -> at N+2 valid=1, msg=RECV_SYNACK, conn=0, seq=0x100, ack=0x200; ack pops, valid=0.
- flags=0x02 (SYN only) and flags=0x10 with unmatched ports -> no message; the unmatched header produces one o_unmatched pulse.
- After SYNACK ack=0x200: four ACKs ack=0x200 with THRESH=3 -> exactly one RECV_DUPACK, emitted on the third; the fourth yields nothing. Then ack=0x300 -> RECV_ACK.
- flags=0x14 (RST+ACK) -> RECV_RST; the following ACK ack=0x200 -> RECV_ACK (la_valid cleared).
- Depth 4, consumer stalled, 6 FIN headers -> 4 queued, o_overflow=1, o_drop_count=2. Then a full-FIFO write with a simultaneous ack is accepted with the count unchanged.
- Slots 1 and 2 configured identically -> conn=1. Assert i_rst low mid-burst -> all outputs return to reset values immediately.
